// File: rtl/fir_input_arbiter_if.sv
// Bus bundle between the per-channel deserializers, the input arbiter and the
// shared FIR core. The arbiter connects through the slave modport; the
// surrounding logic (deserializers + FIR) drives through the master modport.
// Optional macro FIR_ARB_OVERRUN_EN adds the sticky per-channel overrun flags.
interface fir_input_arbiter_if #(
  parameter int NCH    = 4,
  parameter int LENGTH = 24,
  parameter int CHW    = 2
);

  logic [NCH*LENGTH-1:0] iv_din;
  logic [NCH-1:0]        iv_din_valid;
  logic [NCH-1:0]        ov_ready;
  logic                  i_fir_ready;
  logic [LENGTH-1:0]     ov_fir_dout;
  logic                  o_fir_dout_valid;
  logic [CHW-1:0]        ov_fir_ch;
`ifdef FIR_ARB_OVERRUN_EN
  logic [NCH-1:0]        ov_overrun;
`endif

`ifdef FIR_ARB_OVERRUN_EN
  modport slave (
    input  iv_din, iv_din_valid, i_fir_ready,
    output ov_ready, ov_fir_dout, o_fir_dout_valid, ov_fir_ch, ov_overrun
  );

  modport master (
    output iv_din, iv_din_valid, i_fir_ready,
    input  ov_ready, ov_fir_dout, o_fir_dout_valid, ov_fir_ch, ov_overrun
  );
`else
  modport slave (
    input  iv_din, iv_din_valid, i_fir_ready,
    output ov_ready, ov_fir_dout, o_fir_dout_valid, ov_fir_ch
  );

  modport master (
    output iv_din, iv_din_valid, i_fir_ready,
    input  ov_ready, ov_fir_dout, o_fir_dout_valid, ov_fir_ch
  );
`endif

endinterface

// File: rtl/fir_input_arbiter.sv
// fir_input_arbiter: shares one FIR input port between NCH deserializer
// channels. Each channel owns a one-entry holding slot filled by a valid/ready
// handshake; a two-state round-robin FSM issues held samples to the FIR one at
// a time, tagged with the source channel, and holds them under backpressure.
// Optional macro FIR_ARB_OVERRUN_EN adds sticky per-channel overrun flags that
// record samples offered while the channel's slot was still occupied.
module fir_input_arbiter #(
  parameter int NCH    = 4,
  parameter int LENGTH = 24,
  parameter int CHW    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  fir_input_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state;
  logic [NCH-1:0]    slot_full;
  logic [LENGTH-1:0] slot_data [NCH];
  logic [CHW-1:0]    ptr;
  logic [LENGTH-1:0] fir_dout;
  logic              fir_valid;
  logic [CHW-1:0]    fir_ch;

  logic [NCH-1:0]    capture;
  logic [NCH-1:0]    release_mask;
  logic              transfer;
  logic              grant_found;
  logic [CHW-1:0]    grant;
  logic [CHW:0]      idx;
  logic [CHW-1:0]    next_ptr;

  // A channel may deposit only into an empty slot; the ready it sees is the
  // registered empty flag, so the offer path never loops back combinationally.
  assign capture = {NCH{i_en}} & bus.iv_din_valid & ~slot_full;

  // The FIR accepts the held sample only while enabled and in ISSUE.
  assign transfer = i_en & (state == ISSUE) & bus.i_fir_ready;

  // Pointer moves to the channel after the one just served, wrapping at NCH
  // (NCH need not be a power of two, so the wrap is explicit).
  assign next_ptr = (fir_ch == CHW'(NCH - 1)) ? '0 : fir_ch + CHW'(1);

  // One-hot mask of the slot emptied by this cycle's transfer.
  always_comb begin
    release_mask = '0;
    if (transfer) begin
      release_mask[fir_ch] = 1'b1;
    end
  end

  // Round-robin search: first full slot at ptr, ptr+1, ... modulo NCH.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, ptr} + (CHW + 1)'(k);
      if (idx >= (CHW + 1)'(NCH)) begin
        idx = idx - (CHW + 1)'(NCH);
      end
      if (!grant_found && slot_full[idx[CHW-1:0]]) begin
        grant_found = 1'b1;
        grant       = idx[CHW-1:0];
      end
    end
  end

  // Holding slots: independent per-channel capture, emptied only by transfer.
  // Slot data is left in place after a transfer; only the full flag clears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_full <= '0;
      for (int k = 0; k < NCH; k++) begin
        slot_data[k] <= '0;
      end
    end else if (i_en) begin
      slot_full <= (slot_full | capture) & ~release_mask;
      for (int k = 0; k < NCH; k++) begin
        if (capture[k]) begin
          slot_data[k] <= bus.iv_din[k*LENGTH +: LENGTH];
        end
      end
    end
  end

  // Issue FSM: IDLE registers the granted sample onto the FIR port, ISSUE
  // holds it stable until the FIR takes it, then advances the pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      fir_dout  <= '0;
      fir_valid <= 1'b0;
      fir_ch    <= '0;
    end else if (i_en) begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            fir_dout  <= slot_data[grant];
            fir_ch    <= grant;
            fir_valid <= 1'b1;
            state     <= ISSUE;
          end else begin
            fir_valid <= 1'b0;
          end
        end
        ISSUE: begin
          if (bus.i_fir_ready) begin
            fir_valid <= 1'b0;
            ptr       <= next_ptr;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef FIR_ARB_OVERRUN_EN
  logic [NCH-1:0] overrun;

  // Sticky record of samples offered to an occupied slot (those are dropped).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      overrun <= '0;
    end else if (i_en) begin
      overrun <= overrun | (bus.iv_din_valid & slot_full);
    end
  end

  assign bus.ov_overrun = overrun;
`endif

  assign bus.ov_ready         = ~slot_full & {NCH{~i_rst}};
  assign bus.ov_fir_dout      = fir_dout;
  assign bus.o_fir_dout_valid = fir_valid;
  assign bus.ov_fir_ch        = fir_ch;

endmodule

// File: doc/fir_input_arbiter.md
Name: fir_input_arbiter

Overview:
Shares one FIR filter input port between NCH deserializer channels. Each channel deposits a LENGTH-bit sample into a one-entry holding slot using a valid/ready handshake. A round-robin FSM issues held samples to the FIR one at a time, tags each with its source channel, and holds the data under FIR backpressure. It sits between the per-channel deserializers and the shared FIR core.

Parameters:
NCH, 4, number of requesting channels (>=2, need not be a power of two)
LENGTH, 24, sample width in bits
CHW, 2, channel tag width; must equal clog2(NCH)

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous, active-high reset
i_en  in  1  global enable; when low, no capture and FSM frozen
iv_din  in  NCH*LENGTH  packed channel samples; channel k at [k*LENGTH +: LENGTH]
iv_din_valid  in  NCH  per-channel sample valid
ov_ready  out  NCH  per-channel ready to deserializers (slot empty)
i_fir_ready  in  1  FIR can accept a sample this cycle
ov_fir_dout  out  LENGTH  sample to FIR
o_fir_dout_valid  out  1  ov_fir_dout valid
ov_fir_ch  out  CHW  source channel of ov_fir_dout

Behaviour:
- Reset: slot_full all 0; slot data 0; ov_fir_dout 0; o_fir_dout_valid 0; ov_fir_ch 0; rr pointer 0; state IDLE. Reset overrides i_en.
- ov_ready[k] = ~slot_full[k] & ~i_rst. Combinational from a registered flag only; no path from iv_din_valid.
- Capture: at a clock edge where i_en & iv_din_valid[k] & ov_ready[k], slot k <= iv_din[k], and slot_full[k] <= 1. All channels capture independently in the same cycle.
- FSM states: IDLE, ISSUE.
- IDLE, with i_en=1 and any slot_full:
  - Grant = first full channel searching ptr, ptr+1, ..., wrapping mod NCH.
  - Register ov_fir_dout = slot[grant], ov_fir_ch = grant, o_fir_dout_valid = 1.
  - Go to ISSUE.
- IDLE, no full slot: o_fir_dout_valid = 0; stay in IDLE.
- ISSUE, with i_en=1 and i_fir_ready=1 (transfer):
  - slot_full[grant] <= 0.
  - ptr <= grant+1 mod NCH (NCH-1 wraps to 0).
  - o_fir_dout_valid <= 0; go to IDLE.
- ISSUE, i_fir_ready=0: hold ov_fir_dout, ov_fir_ch and valid stable; remain in ISSUE.
- Latency: sample captured at edge E is visible on ov_fir_dout after edge E+1 if the FSM is idle. Peak throughput is 1 sample per 2 cycles.
- The slot being cleared cannot be recaptured in the same cycle, because ready derives from the registered flag. ov_ready[grant] rises the cycle after transfer.
- Samples captured while in ISSUE compete at the next IDLE. Fairness is strict round-robin from ptr; the last-served channel is lowest priority.
- i_en=0: no captures, no state or pointer change, outputs hold their current values (including valid=1 if in ISSUE). A transfer is not taken while i_en=0.
- Reset mid-ISSUE: pending sample discarded, valid 0 on the next cycle, all slots emptied.
- Slot data is not cleared on transfer; only the full flag is.

Optional Feature:
FIR_ARB_OVERRUN_EN:
- Defined: adds output port ov_overrun (NCH, out). Bit k is sticky and is set at an edge where i_en & iv_din_valid[k] & slot_full[k] (sample offered while slot busy; sample is dropped). It is cleared only by i_rst (reset value 0).
- Undefined: port and logic are absent; offered-while-full samples are silently ignored.

Test Plan:
1. Assert i_rst 3 cycles, then deassert -> ov_ready=4'b1111, o_fir_dout_valid=0, ov_fir_dout=0, ov_fir_ch=0.
2. Channel 2 valid with 24'hABCDEF for 1 cycle, i_fir_ready=1 -> valid=1, ov_fir_ch=2, ov_fir_dout=24'hABCDEF for exactly 1 cycle, 2 edges after capture. ov_ready[2] is low for 2 cycles, then high.
3. All 4 channels valid in one cycle (data 24'h000001..24'h000004), i_fir_ready=1 -> issue order ch0,1,2,3 with matching data, 2 cycles apart. Then ch0 and ch3 refill while ptr=0 -> ch0 before ch3.
4. Channel 1 sample 24'h123456, i_fir_ready=0 for 5 cycles then 1 -> valid and data stay stable for 6 cycles, transfer on the 6th, ov_ready[1] stays low until the cycle after.
5. Channel 0 in ISSUE with i_fir_ready=0, then pulse i_rst -> next cycle valid=0, ov_ready=4'b1111. No stale sample issues after reset.
6. With FIR_ARB_OVERRUN_EN defined: fill ch3, hold i_fir_ready=0, offer a second ch3 sample -> ov_overrun=4'b1000 persists after the drain. The first sample is delivered and the second is never issued.
